// File: rtl/gemm_wave_ctrl_pkg.sv
// Shared types, mode encodings and sizing helpers for the GEMM wave controller.
package gemm_wave_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } gemm_wave_state_t;

  localparam logic [1:0] MODE_WIDE     = 2'b00;
  localparam logic [1:0] MODE_VERT     = 2'b01;
  localparam logic [1:0] MODE_TALLWIDE = 2'b10;
  localparam logic [1:0] MODE_TALL     = 2'b11;

  // Phase counter must hold the largest size input and the longest drain.
  function automatic int unsigned cnt_width(input int unsigned dim_w,
                                            input int unsigned rows,
                                            input int unsigned cols);
    int unsigned skew_w;
    skew_w = $clog2(rows + 2 * cols);
    return ((dim_w > skew_w) ? dim_w : skew_w) + 1;
  endfunction

  function automatic int unsigned drain_len(input int unsigned rows,
                                            input int unsigned cols,
                                            input logic        wide);
    return rows + cols - 1 + (wide ? cols : 0);
  endfunction

endpackage

// File: rtl/gemm_wave_ctrl_if.sv
// Command/status and datapath strobe bundle between the GEMM command side and gemm_wave_ctrl.
interface gemm_wave_ctrl_if #(
  parameter int unsigned DIM_W = 5
);
  logic             start;
  logic [DIM_W-1:0] ksize;
  logic [DIM_W-1:0] msize;
  logic [1:0]       mode;
  logic             if_mux_sel;
  logic             w_mux_sel;
  logic             stall;

  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       mode_q;
  logic             if_mux_sel_q;
  logic             w_mux_sel_q;
  logic             w_load_en;
  logic [DIM_W-1:0] w_row_idx;
  logic             if_valid;
  logic [DIM_W-1:0] if_row_idx;
  logic             acc_clear;
  logic [31:0]      perf_cycles;

  modport master (
    output start, ksize, msize, mode, if_mux_sel, w_mux_sel, stall,
    input  busy, done, err, mode_q, if_mux_sel_q, w_mux_sel_q,
           w_load_en, w_row_idx, if_valid, if_row_idx, acc_clear, perf_cycles
  );

  modport slave (
    input  start, ksize, msize, mode, if_mux_sel, w_mux_sel, stall,
    output busy, done, err, mode_q, if_mux_sel_q, w_mux_sel_q,
           w_load_en, w_row_idx, if_valid, if_row_idx, acc_clear, perf_cycles
  );
endinterface

// File: rtl/gemm_wave_ctrl_phase_counter.sv
// Loadable down-counter for one wave phase; reports the last step, the first step
// and the up-going row index (load value minus remaining count).
module gemm_phase_counter #(
  parameter int unsigned CW = 6,
  parameter int unsigned IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          last,
  output logic          first,
  output logic [IW-1:0] idx
);

  logic [CW-1:0] count;
  logic [CW-1:0] base;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      base  <= '0;
    end else if (load) begin
      count <= load_val;
      base  <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last  = (count == CW'(1));
  assign first = (count == base);
  assign idx   = IW'(base - count);

  a_no_wrap: assert property (@(posedge clk) disable iff (rst)
    (en && !load) |-> (count != '0));

endmodule

// File: rtl/gemm_wave_ctrl.sv
// Sequences one GEMM tile through weight-load, feature stream, drain and done phases.
// Optional busy-cycle counter: define GEMM_WAVE_PERF_CNT_EN.
module gemm_wave_ctrl
  import gemm_wave_ctrl_pkg::*;
#(
  parameter int unsigned SYS_ROWS = 8,
  parameter int unsigned SYS_COLS = 8,
  parameter int unsigned DIM_W    = 5
) (
  input logic           clk,
  input logic           rst,
  gemm_wave_ctrl_if.slave bus
);

  localparam int unsigned    CW         = cnt_width(DIM_W, SYS_ROWS, SYS_COLS);
  localparam logic [CW-1:0]  DRAIN_NARW = CW'(drain_len(SYS_ROWS, SYS_COLS, 1'b0));
  localparam logic [CW-1:0]  DRAIN_WIDE = CW'(drain_len(SYS_ROWS, SYS_COLS, 1'b1));

  gemm_wave_state_t state, state_nxt;

  logic [1:0]       mode_q;
  logic             if_mux_sel_q;
  logic             w_mux_sel_q;
  logic [DIM_W-1:0] msize_q;
  logic             err_q;

  logic             start_acc;
  logic             zero_size;
  logic             cnt_load;
  logic             cnt_en;
  logic [CW-1:0]    cnt_val;
  logic             cnt_last;
  logic             cnt_first;
  logic [DIM_W-1:0] cnt_idx;

  assign start_acc = (state == IDLE) && bus.start;
  assign zero_size = (bus.ksize == '0) || (bus.msize == '0);

  gemm_phase_counter #(
    .CW (CW),
    .IW (DIM_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .last     (cnt_last),
    .first    (cnt_first),
    .idx      (cnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= MODE_TALL;
      if_mux_sel_q <= 1'b0;
      w_mux_sel_q  <= 1'b0;
      msize_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        mode_q       <= bus.mode;
        if_mux_sel_q <= bus.if_mux_sel;
        w_mux_sel_q  <= bus.w_mux_sel;
        msize_q      <= bus.msize;
        err_q        <= zero_size;
      end
    end
  end

  // Each phase reloads the shared counter on the step that retires its last row.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_val   = '0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (zero_size) begin
            state_nxt = DONE;
          end else begin
            state_nxt = LOAD_W;
            cnt_load  = 1'b1;
            cnt_val   = CW'(bus.ksize);
          end
        end
      end
      LOAD_W: begin
        if (!bus.stall) begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_nxt = STREAM;
            cnt_load  = 1'b1;
            cnt_val   = CW'(msize_q);
          end
        end
      end
      STREAM: begin
        if (!bus.stall) begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_nxt = DRAIN;
            cnt_load  = 1'b1;
            cnt_val   = mode_q[0] ? DRAIN_NARW : DRAIN_WIDE;
          end
        end
      end
      DRAIN: begin
        if (!bus.stall) begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.err          = err_q;
  assign bus.mode_q       = mode_q;
  assign bus.if_mux_sel_q = if_mux_sel_q;
  assign bus.w_mux_sel_q  = w_mux_sel_q;
  assign bus.w_load_en    = (state == LOAD_W) && !bus.stall;
  assign bus.w_row_idx    = (state == LOAD_W) ? cnt_idx : '0;
  assign bus.if_valid     = (state == STREAM) && !bus.stall;
  assign bus.if_row_idx   = (state == STREAM) ? cnt_idx : '0;
  assign bus.acc_clear    = (state == STREAM) && !bus.stall && cnt_first;

`ifdef GEMM_WAVE_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if ((state != IDLE) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

  a_done_one_cycle: assert property (@(posedge clk) disable iff (rst)
    (state == DONE) |=> (state == IDLE));

endmodule

// File: tb/tb_gemm_wave_ctrl.sv
// Scoreboard bench for gemm_wave_ctrl: a per-cycle expected trace is queued per tile,
// and a negedge monitor pops and compares it while the DUT reports busy.
module tb_gemm_wave_ctrl;
  localparam int unsigned SYS_ROWS = 8;
  localparam int unsigned SYS_COLS = 8;
  localparam int unsigned DIM_W    = 5;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  int   busy_cnt, done_cnt, done_cyc;

  typedef struct {
    int       cyc;
    bit       w_en;
    int       w_idx;
    bit       w_chk;
    bit       if_v;
    int       if_idx;
    bit       if_chk;
    bit       acc;
    bit       done;
    bit       err;
    logic [1:0] mode;
    bit       ifs;
    bit       ws;
  } ev_t;

  ev_t sb[$];
  ev_t me;

  gemm_wave_ctrl_if #(.DIM_W(DIM_W)) bus();

  gemm_wave_ctrl #(
    .SYS_ROWS (SYS_ROWS),
    .SYS_COLS (SYS_COLS),
    .DIM_W    (DIM_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy) begin
        busy_cnt++;
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        chk("trace_entry", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          me = sb.pop_front();
          chk("cycle", cyc, me.cyc);
          chk("strobes", {bus.w_load_en, bus.if_valid, bus.acc_clear, bus.done},
              {me.w_en, me.if_v, me.acc, me.done});
          if (me.w_chk)  chk("w_row_idx", bus.w_row_idx, me.w_idx);
          if (me.if_chk) chk("if_row_idx", bus.if_row_idx, me.if_idx);
          chk("err", bus.err, me.err);
          chk("latched_q", {bus.mode_q, bus.if_mux_sel_q, bus.w_mux_sel_q},
              {me.mode, me.ifs, me.ws});
        end
      end else begin
        chk("idle_strobes", {bus.w_load_en, bus.if_valid, bus.acc_clear, bus.done}, 0);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_strobes", {bus.w_load_en, bus.if_valid, bus.acc_clear}, 0);
    chk("rst_mode_q", bus.mode_q, 3);
    chk("rst_mux_q", {bus.if_mux_sel_q, bus.w_mux_sel_q}, 0);
    chk("rst_idx", {bus.w_row_idx, bus.if_row_idx}, 0);
    chk("rst_perf", bus.perf_cycles, 0);
  endtask

  // Model: walk the phase lengths, spending stalled cycles in place, one trace entry per busy cycle.
  task automatic run_tile(input int k, input int m, input logic [1:0] md, input bit ifs,
                          input bit ws, input int pct, input int st_lo, input int st_hi,
                          input bit meddle, input int rst_rel, input int exp_done);
    bit     stl[2048];
    ev_t    tr[$];
    ev_t    e, x;
    int     c0, d, t, t_done, end_rel;
    bit     zero, adv;
    longint exp_perf;

    for (int r = 0; r < 2048; r++)
      stl[r] = (r < 1000) && (($urandom_range(0, 99) < pct) || (r >= st_lo && r <= st_hi));

    c0   = cyc;
    zero = (k == 0) || (m == 0);
    d    = SYS_ROWS + SYS_COLS - 1 + ((md[0] == 1'b0) ? SYS_COLS : 0);
    e    = '{default: 0};
    e.mode = md; e.ifs = ifs; e.ws = ws; e.err = zero;
    t = 1;
    if (!zero) begin
      for (int i = 0; i < k; i++) begin
        do begin
          x = e; x.cyc = c0 + t; x.w_chk = 1; x.w_idx = i; x.w_en = !stl[t];
          adv = !stl[t]; tr.push_back(x); t++;
        end while (!adv);
      end
      for (int j = 0; j < m; j++) begin
        do begin
          x = e; x.cyc = c0 + t; x.if_chk = 1; x.if_idx = j; x.if_v = !stl[t];
          x.acc = (j == 0) && !stl[t];
          adv = !stl[t]; tr.push_back(x); t++;
        end while (!adv);
      end
      for (int n = 0; n < d; n++) begin
        do begin
          x = e; x.cyc = c0 + t;
          adv = !stl[t]; tr.push_back(x); t++;
        end while (!adv);
      end
    end
    x = e; x.cyc = c0 + t; x.done = 1; tr.push_back(x);
    t_done = t;

    if (rst_rel >= t_done) rst_rel = -1;
    end_rel = (rst_rel >= 0) ? rst_rel : t_done;
    foreach (tr[i]) if (tr[i].cyc <= c0 + end_rel) sb.push_back(tr[i]);
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;

    for (int r = 0; r <= end_rel; r++) begin
      rst       = (r == rst_rel);
      bus.start = (r == 0) || meddle;
      if (r == 0 || !meddle) begin
        bus.ksize = DIM_W'(k); bus.msize = DIM_W'(m); bus.mode = md;
        bus.if_mux_sel = ifs; bus.w_mux_sel = ws;
      end else begin
        bus.ksize = DIM_W'($urandom); bus.msize = DIM_W'($urandom);
        bus.mode = 2'($urandom); bus.if_mux_sel = 1'($urandom); bus.w_mux_sel = 1'($urandom);
      end
      bus.stall = stl[r];
      @(posedge clk); #1;
    end
    rst = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
    @(negedge clk);

    chk("busy_cycles", busy_cnt, end_rel);
    chk("done_pulses", done_cnt, (rst_rel < 0) ? 1 : 0);
    chk("trace_drained", sb.size(), 0);
    sb.delete();
    if (exp_done >= 0) chk("done_cycle", done_cyc - c0, exp_done);
`ifdef GEMM_WAVE_PERF_CNT_EN
    exp_perf = (rst_rel < 0) ? longint'(t_done) : 0;
`else
    exp_perf = 0;
`endif
    chk("perf_cycles", bus.perf_cycles, exp_perf);
    if (rst_rel >= 0) check_reset_vals();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.ksize = '0; bus.msize = '0; bus.mode = 2'b00;
    bus.if_mux_sel = 1'b0; bus.w_mux_sel = 1'b0; bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    mon_en = 1'b1;

    //        k  m  mode   ifs ws pct lo  hi  med rst exp
    run_tile(4, 3, 2'b11, 1, 0, 0, -1, -1, 0, -1, 23);
    run_tile(4, 3, 2'b10, 0, 1, 0, -1, -1, 0, -1, 31);
    run_tile(4, 3, 2'b11, 1, 1, 0,  2,  3, 0, -1, 25);
    run_tile(0, 3, 2'b01, 1, 0, 0, -1, -1, 0, -1, 1);
    run_tile(2, 2, 2'b11, 0, 0, 0, -1, -1, 0, -1, 20);
    run_tile(3, 0, 2'b00, 1, 1, 0, -1, -1, 0, -1, 1);
    run_tile(4, 3, 2'b11, 1, 1, 0, -1, -1, 0,  6, -1);
    run_tile(5, 4, 2'b01, 1, 0, 0, -1, -1, 1, -1, 25);
    run_tile(31, 31, 2'b00, 0, 1, 0, -1, -1, 0, -1, 1 + 31 + 31 + 23);

    for (int n = 0; n < 40; n++) begin
      run_tile($urandom_range(0, 20), $urandom_range(0, 20), 2'($urandom),
               1'($urandom), 1'($urandom), $urandom_range(0, 40), -1, -1,
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 30)) : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
